// File: rtl/slave_in.sv
// Slave-side serial receiver: deserialises the master's LSB-first address,
// burst and data lanes into local memory write strobes (write frames) or a
// single read request to the return-path block (read frames).
module slave_in #(
  parameter int ADDR_LEN  = 12,
  parameter int DATA_LEN  = 8,
  parameter int BURST_LEN = 12,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sel,
  input  logic                 write_en,
  input  logic                 read_en,
  input  logic                 master_valid,
  input  logic                 rx_address,
  input  logic                 rx_data,
  input  logic                 rx_burst,
  input  logic                 rd_done,
  output logic                 slave_ready,
  output logic                 mem_we,
  output logic [ADDR_LEN-1:0]  mem_addr,
  output logic [DATA_LEN-1:0]  mem_wdata,
  output logic                 rd_req,
  output logic [ADDR_LEN-1:0]  rd_addr,
  output logic [BURST_LEN-1:0] rd_len,
  output logic                 wr_done,
  output logic                 err
);

  // Header ends once both the address and the burst field are in.
  localparam int H  = (ADDR_LEN - 1 > BURST_LEN) ? ADDR_LEN - 1 : BURST_LEN;
  localparam int KW = $clog2(H + 2);
  localparam int PW = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;
  localparam int SW = $clog2(TIMEOUT + 1);

  localparam logic [KW-1:0] K_ALEN  = KW'(ADDR_LEN);
  localparam logic [KW-1:0] K_BLEN  = KW'(BURST_LEN);
  localparam logic [KW-1:0] K_H     = KW'(H);
  localparam logic [KW-1:0] K_SAT   = KW'(H + 1);
  localparam logic [PW-1:0] K_DLAST = PW'(DATA_LEN - 1);
  localparam logic [SW-1:0] K_TO1   = SW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RX, S_RWAIT} state_t;

  // A zero burst field still carries one beat.
  function automatic logic [BURST_LEN-1:0] beats_of(input logic [BURST_LEN-1:0] burst);
    return (burst == '0) ? BURST_LEN'(1) : burst;
  endfunction

  state_t               r_state;
  logic                 r_is_wr;
  logic [KW-1:0]        r_k;          // frame bit index, saturates past the header
  logic [PW-1:0]        r_pos;        // bit position inside the current beat
  logic [BURST_LEN-1:0] r_bcnt;       // beats completed on the data lane
  logic [BURST_LEN-1:0] r_wcnt;       // beats written to memory
  logic [SW-1:0]        r_stall;
  logic                 r_hdr;
  logic                 r_hold_vld;
  logic [ADDR_LEN-1:0]  r_addr;
  logic [BURST_LEN-1:0] r_burst;
  logic [DATA_LEN-1:0]  r_shift;
  logic [DATA_LEN-1:0]  r_hold;

  logic                 r_ready, r_mem_we, r_rd_req, r_wr_done, r_err;
  logic [ADDR_LEN-1:0]  r_mem_addr, r_rd_addr;
  logic [DATA_LEN-1:0]  r_mem_wdata;
  logic [BURST_LEN-1:0] r_rd_len;

  logic                 w_cap, w_addr_cap, w_burst_cap;
  logic [ADDR_LEN-1:0]  w_addr_next, w_waddr;
  logic [BURST_LEN-1:0] w_burst_next, w_beats;
  logic [DATA_LEN-1:0]  w_shift_next, w_wdata;
  logic                 w_hdr_now, w_hdr, w_beat_done, w_hold_issue, w_direct, w_to_hold;
  logic                 w_we, w_final, w_issue, w_stall_to, w_abort;

  // Lane capture and write scheduling for the current cycle.
  always_comb begin
    w_cap        = (r_state == S_RX) && master_valid;
    w_addr_cap   = w_cap && (r_k < K_ALEN);
    w_burst_cap  = w_cap && (r_k != '0) && (r_k <= K_BLEN);
    w_addr_next  = w_addr_cap  ? {rx_address, r_addr[ADDR_LEN-1:1]}  : r_addr;
    w_burst_next = w_burst_cap ? {rx_burst, r_burst[BURST_LEN-1:1]}  : r_burst;
    w_shift_next = {rx_data, r_shift[DATA_LEN-1:1]};
    w_hdr_now    = w_cap && (r_k == K_H);
    w_hdr        = r_hdr || w_hdr_now;
    w_beats      = beats_of(w_burst_next);
    // Beats past the last one are dropped once the burst length is known.
    w_beat_done  = w_cap && r_is_wr && (r_pos == K_DLAST) && (!w_hdr || (r_bcnt < w_beats));
    w_hold_issue = (r_state == S_RX) && r_is_wr && r_hold_vld && w_hdr;
    w_direct     = w_beat_done && w_hdr && !w_hold_issue;
    w_to_hold    = w_beat_done && (!w_hdr || w_hold_issue);
    w_we         = w_hold_issue || w_direct;
    w_wdata      = w_hold_issue ? r_hold : w_shift_next;
    w_waddr      = w_addr_next + ADDR_LEN'(r_wcnt);
    w_final      = w_we && (r_wcnt == w_beats - BURST_LEN'(1));
    w_stall_to   = (r_state == S_RX) && !master_valid && (r_k != '0) && (r_stall == K_TO1);
    w_abort      = (r_state == S_RX) && (!sel || (!write_en && !read_en) || w_stall_to);
    // A completing final write beats a simultaneous abort; other writes do not.
    w_issue      = w_we && (w_final || !w_abort);
  end

  // Lane shift registers; always fully refilled before use, so no reset.
  always_ff @(posedge clk) begin
    r_addr  <= w_addr_next;
    r_burst <= w_burst_next;
    if (w_cap)     r_shift <= w_shift_next;
    if (w_to_hold) r_hold  <= w_shift_next;
  end

  // Frame state machine, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_is_wr     <= 1'b0;
      r_k         <= '0;
      r_pos       <= '0;
      r_bcnt      <= '0;
      r_wcnt      <= '0;
      r_stall     <= '0;
      r_hdr       <= 1'b0;
      r_hold_vld  <= 1'b0;
      r_ready     <= 1'b1;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rd_req    <= 1'b0;
      r_rd_addr   <= '0;
      r_rd_len    <= '0;
      r_wr_done   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_mem_we  <= 1'b0;
      r_rd_req  <= 1'b0;
      r_wr_done <= 1'b0;
      r_err     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (sel && (write_en ^ read_en)) begin
            r_state    <= S_RX;
            r_is_wr    <= write_en;
            r_k        <= '0;
            r_pos      <= '0;
            r_bcnt     <= '0;
            r_wcnt     <= '0;
            r_stall    <= '0;
            r_hdr      <= 1'b0;
            r_hold_vld <= 1'b0;
          end
        end
        S_RX: begin
          if (master_valid) begin
            r_stall <= '0;
            if (r_k != K_SAT) r_k <= r_k + KW'(1);
            r_pos <= (r_pos == K_DLAST) ? '0 : r_pos + PW'(1);
          end else if (r_k != '0) begin
            r_stall <= r_stall + SW'(1);
          end
          if (w_hdr_now)   r_hdr  <= 1'b1;
          if (w_beat_done) r_bcnt <= r_bcnt + BURST_LEN'(1);
          if (w_to_hold)         r_hold_vld <= 1'b1;
          else if (w_hold_issue) r_hold_vld <= 1'b0;
          if (w_issue) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= w_waddr;
            r_mem_wdata <= w_wdata;
            r_wcnt      <= r_wcnt + BURST_LEN'(1);
          end
          if (w_final) begin
            r_wr_done <= 1'b1;
            r_state   <= S_IDLE;
          end else if (!r_is_wr && w_hdr_now) begin
            r_rd_req  <= 1'b1;
            r_rd_addr <= w_addr_next;
            r_rd_len  <= w_burst_next;
            r_ready   <= 1'b0;
            r_state   <= S_RWAIT;
          end else if (w_abort) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        S_RWAIT: begin
          if (rd_done) begin
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign slave_ready = r_ready;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign rd_req      = r_rd_req;
  assign rd_addr     = r_rd_addr;
  assign rd_len      = r_rd_len;
  assign wr_done     = r_wr_done;
  assign err         = r_err;

endmodule

// File: tb/tb_slave_in.sv
// Scoreboard bench for slave_in: stimulus pushes expected strobes with the
// cycle they must appear in; a monitor pops and compares on every strobe.
module tb_slave_in;

  logic        clk = 1'b0;
  logic        reset, sel, write_en, read_en, master_valid;
  logic        rx_address, rx_data, rx_burst, rd_done;
  logic        slave_ready, mem_we, rd_req, wr_done, err;
  logic [11:0] mem_addr, rd_addr, rd_len;
  logic [7:0]  mem_wdata;

  slave_in dut (
    .clk(clk), .reset(reset), .sel(sel), .write_en(write_en), .read_en(read_en),
    .master_valid(master_valid), .rx_address(rx_address), .rx_data(rx_data),
    .rx_burst(rx_burst), .rd_done(rd_done), .slave_ready(slave_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .rd_req(rd_req),
    .rd_addr(rd_addr), .rd_len(rd_len), .wr_done(wr_done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [11:0] addr; logic [7:0] data; bit last; int c; } wr_t;
  typedef struct { logic [11:0] addr; logic [11:0] len; int c; } rd_t;
  wr_t wq[$];
  rd_t rq[$];
  int  eq[$];

  int checks = 0;
  int failures = 0;
  logic [7:0] beat_data [0:7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_lanes();
    sel = 0; write_en = 0; read_en = 0; master_valid = 0;
    rx_address = 0; rx_data = 0; rx_burst = 0; rd_done = 0;
  endtask

  task automatic chk_reset_vals(input string name);
    chk(name, {slave_ready, mem_we, mem_addr, mem_wdata, rd_req, rd_addr, rd_len, wr_done, err},
        {1'b1, 48'h0});
  endtask

  // Drive one frame; optional stall before sample stall_k, sel drop at
  // sel_k, or reset at reset_k (-1 disables each).
  task automatic frame(input bit wr, input logic [11:0] addr, input logic [11:0] burst,
                       input int stall_k, input int stall_n, input int sel_k, input int reset_k);
    int beats, n, kb;
    logic [11:0] a, bu;
    logic [7:0]  d;
    a = addr; bu = burst;
    beats = (burst == 0) ? 1 : int'(burst);
    n = wr ? (((beats * 8 - 1) > 12) ? beats * 8 : 13) : 13;
    sel = 1; write_en = wr; read_en = !wr; master_valid = 0;
    step();
    for (int k = 0; k < n; k++) begin
      if (k == stall_k) begin
        for (int i = 0; i < stall_n; i++) begin
          master_valid = 0;
          step();
          if (i == 15) begin
            eq.push_back(cyc);
            idle_lanes();
            return;
          end
        end
      end
      if (k == reset_k) begin
        reset = 1; master_valid = 0;
        step();
        reset = 0;
        idle_lanes();
        chk_reset_vals("reset_midframe_outputs");
        return;
      end
      if (k == sel_k) sel = 0;
      master_valid = 1;
      rx_address = (k < 12) ? a[k] : 1'b0;
      rx_burst   = (k >= 1 && k <= 12) ? bu[k-1] : 1'b0;
      d = (k / 8 < 8) ? beat_data[k/8] : 8'h00;
      rx_data = d[k%8];
      step();
      if (k == sel_k) begin
        eq.push_back(cyc);
        idle_lanes();
        return;
      end
      if (wr) begin
        for (int b = 0; b < beats; b++) begin
          kb = ((b + 1) * 8 - 1 > 12) ? (b + 1) * 8 - 1 : 12;
          if (k == kb) wq.push_back('{addr: a + 12'(b), data: beat_data[b], last: (b == beats - 1), c: cyc});
        end
      end else if (k == 12) begin
        rq.push_back('{addr: a, len: bu, c: cyc});
        chk("read_ready_low", slave_ready, 1'b0);
      end
    end
    idle_lanes();
  endtask

  // Monitor: every strobe must match the head of its queue.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_we) begin
        if (wq.size() == 0) chk("unexpected_mem_we", mem_we, 1'b0);
        else begin
          wr_t e;
          e = wq.pop_front();
          chk("we_addr", mem_addr, e.addr);
          chk("we_data", mem_wdata, e.data);
          chk("we_wr_done", wr_done, e.last);
          chk("we_cycle", cyc, e.c);
        end
      end else if (wr_done) chk("unexpected_wr_done", wr_done, 1'b0);
      if (rd_req) begin
        if (rq.size() == 0) chk("unexpected_rd_req", rd_req, 1'b0);
        else begin
          rd_t r;
          r = rq.pop_front();
          chk("rd_addr", rd_addr, r.addr);
          chk("rd_len", rd_len, r.len);
          chk("rd_cycle", cyc, r.c);
        end
      end
      if (err) begin
        if (eq.size() == 0) chk("unexpected_err", err, 1'b0);
        else chk("err_cycle", cyc, eq.pop_front());
      end
    end
  end

  initial begin
    idle_lanes();
    for (int i = 0; i < 8; i++) beat_data[i] = 8'h00;
    reset = 1;
    step(); step();
    reset = 0;
    chk_reset_vals("reset_outputs");
    step();

    // Single write, burst 0.
    beat_data[0] = 8'h3C;
    frame(1'b1, 12'h0A5, 12'd0, -1, 0, -1, -1);
    repeat (3) step();

    // Burst of three with address wrap.
    beat_data[0] = 8'h11; beat_data[1] = 8'h22; beat_data[2] = 8'h33;
    frame(1'b1, 12'hFFE, 12'd3, -1, 0, -1, -1);
    repeat (3) step();

    // Read request and return-path handshake.
    frame(1'b0, 12'h123, 12'd5, -1, 0, -1, -1);
    repeat (3) step();
    chk("read_wait_ready_low", slave_ready, 1'b0);
    rd_done = 1;
    step();
    rd_done = 0;
    chk("ready_after_rd_done", slave_ready, 1'b1);
    repeat (2) step();

    // Short stall: same write, later.
    beat_data[0] = 8'h3C; beat_data[1] = 8'h00; beat_data[2] = 8'h00;
    frame(1'b1, 12'h0A5, 12'd0, 4, 5, -1, -1);
    repeat (3) step();

    // Long stall: timeout abort.
    frame(1'b1, 12'h0A5, 12'd0, 4, 16, -1, -1);
    step();
    chk("ready_after_timeout", slave_ready, 1'b1);
    repeat (2) step();

    // Reset between beat 1 and beat 2.
    beat_data[0] = 8'h11; beat_data[1] = 8'h22; beat_data[2] = 8'h33;
    frame(1'b1, 12'hFFE, 12'd3, -1, 0, -1, 18);
    repeat (3) step();

    // Both enables high: stays idle, nothing toggles.
    sel = 1; write_en = 1; read_en = 1;
    for (int i = 0; i < 20; i++) begin
      master_valid = 1; rx_address = i[0]; rx_data = i[1]; rx_burst = i[2];
      step();
    end
    chk("ready_both_enables", slave_ready, 1'b1);
    idle_lanes();
    repeat (2) step();

    // sel dropped mid-frame.
    beat_data[0] = 8'h3C; beat_data[1] = 8'h00; beat_data[2] = 8'h00;
    frame(1'b1, 12'h0A5, 12'd0, -1, 0, 6, -1);
    repeat (3) step();

    // Recovery: burst field 1 is one beat.
    beat_data[0] = 8'hA5;
    frame(1'b1, 12'h7FF, 12'd1, -1, 0, -1, -1);
    repeat (5) step();

    chk("write_queue_drained", wq.size(), 0);
    chk("read_queue_drained", rq.size(), 0);
    chk("err_queue_drained", eq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
